// File: rtl/prbs31_checker.sv
// rtl/prbs31_checker.sv - PRBS31 (x^31 + x^28 + 1) receive checker with self-seeding and loss-of-lock.
// Optional PRBS31_CHK_BITCNT_EN adds a 32-bit count of checked bits for BER computation.
module prbs31_checker #(
  parameter int ERR_CNT_W   = 16,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din_valid,
  input  logic                 din,
  input  logic                 clr_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt
`ifdef PRBS31_CHK_BITCNT_EN
  ,
  output logic [31:0]          bit_cnt
`endif
);

  localparam int WIN_W = $clog2(WINDOW + 1);

  typedef enum logic {SEED, CHECK} state_t;

  state_t           state;
  logic [30:0]      sr;
  logic [4:0]       seed_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W-1:0] win_err;

  logic             exp_bit;
  logic             err;
  logic [30:0]      seed_sr;
  logic [WIN_W-1:0] win_err_nxt;
  logic             win_end;
  logic             cnt_max;

  // sr[0] is the newest bit, so sr[27] and sr[30] are s[n-28] and s[n-31]
  assign exp_bit     = sr[27] ^ sr[30];
  assign err         = din ^ exp_bit;
  assign seed_sr     = {sr[29:0], din};
  assign win_err_nxt = win_err + WIN_W'(err);
  assign win_end     = (win_cnt == WIN_W'(WINDOW - 1));
  assign cnt_max     = &err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEED;
      sr        <= '0;
      seed_cnt  <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
`ifdef PRBS31_CHK_BITCNT_EN
      bit_cnt   <= '0;
`endif
    end else begin
      err_pulse <= 1'b0;
      if (din_valid) begin
        case (state)
          SEED: begin
            sr <= seed_sr;
            if (seed_cnt == 5'd30) begin
              seed_cnt <= '0;
              // an all-zero seed would lock onto a stuck-at-0 line, so keep seeding
              if (|seed_sr) begin
                state   <= CHECK;
                locked  <= 1'b1;
                win_cnt <= '0;
                win_err <= '0;
              end
            end else begin
              seed_cnt <= seed_cnt + 5'd1;
            end
          end
          CHECK: begin
            // shift the prediction, not din, so a single line error is counted once
            sr        <= {sr[29:0], exp_bit};
            err_pulse <= err;
            if (err && !cnt_max)
              err_cnt <= err_cnt + ERR_CNT_W'(1);
`ifdef PRBS31_CHK_BITCNT_EN
            bit_cnt <= bit_cnt + 32'd1;
`endif
            if (win_end) begin
              win_cnt <= '0;
              win_err <= '0;
              if (win_err_nxt >= WIN_W'(LOSS_THRESH)) begin
                state    <= SEED;
                locked   <= 1'b0;
                seed_cnt <= '0;
              end
            end else begin
              win_cnt <= win_cnt + WIN_W'(1);
              win_err <= win_err_nxt;
            end
          end
          default: state <= SEED;
        endcase
      end
      if (clr_cnt) begin
        err_cnt <= '0;
`ifdef PRBS31_CHK_BITCNT_EN
        bit_cnt <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_prbs31_checker.sv
// tb/tb_prbs31_checker.sv - scoreboard bench for prbs31_checker, two parameterisations on one stimulus stream.
module tb_prbs31_checker;

  localparam int WIN = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din_valid = 1'b0;
  logic din = 1'b0;
  logic clr_cnt = 1'b0;

  logic        locked0, locked1, pulse0, pulse1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;
  logic        locked_w [2];
  logic        pulse_w  [2];
  logic [15:0] cnt_w    [2];
  logic [31:0] bc_w     [2];

`ifdef PRBS31_CHK_BITCNT_EN
  logic [31:0] bc0, bc1;
  assign bc_w[0] = bc0;
  assign bc_w[1] = bc1;
`else
  assign bc_w[0] = '0;
  assign bc_w[1] = '0;
`endif

  assign locked_w[0] = locked0;
  assign locked_w[1] = locked1;
  assign pulse_w[0]  = pulse0;
  assign pulse_w[1]  = pulse1;
  assign cnt_w[0]    = cnt0;
  assign cnt_w[1]    = {12'd0, cnt1};

  prbs31_checker #(.ERR_CNT_W(16), .WINDOW(WIN), .LOSS_THRESH(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
    .locked(locked0), .err_pulse(pulse0), .err_cnt(cnt0)
`ifdef PRBS31_CHK_BITCNT_EN
    , .bit_cnt(bc0)
`endif
  );

  prbs31_checker #(.ERR_CNT_W(4), .WINDOW(WIN), .LOSS_THRESH(WIN)) dut1 (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
    .locked(locked1), .err_pulse(pulse1), .err_cnt(cnt1)
`ifdef PRBS31_CHK_BITCNT_EN
    , .bit_cnt(bc1)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        locked;
    logic        pulse;
    logic [15:0] cnt;
    logic [31:0] bits;
  } exp_t;

  // reference model: a sequence-level view of the checker, per instance
  int          m_th  [2] = '{8, WIN};
  int          m_max [2] = '{65535, 15};
  bit          m_chk [2];
  int          m_seed_n [2];
  int          m_wb  [2];
  int          m_we  [2];
  int          m_cnt [2];
  logic [31:0] m_bits [2];
  bit          hist [2][$];
  exp_t        sbq  [2][$];
  bit          gen [$];

  int nvec = 0;
  int nmis = 0;
  int npulse [2];
  int nunlk  [2];
  int nlk    [2];

  function automatic bit gen_next();
    int n;
    bit b;
    n = gen.size();
    b = gen[n-28] ^ gen[n-31];
    gen.push_back(b);
    void'(gen.pop_front());
    return b;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_chk[d] = 1'b0;
      m_seed_n[d] = 0;
      m_wb[d] = 0;
      m_we[d] = 0;
      m_cnt[d] = 0;
      m_bits[d] = '0;
      hist[d].delete();
      sbq[d].delete();
    end
  endfunction

  function automatic void model_step(input int d, input logic v, input logic b, input logic c);
    exp_t e;
    bit   was;
    bit   er;
    bit   p;
    int   n;
    int   ones;
    was = m_chk[d];
    er = 1'b0;
    if (v) begin
      if (!m_chk[d]) begin
        hist[d].push_back(b);
        if (hist[d].size() > 31) void'(hist[d].pop_front());
        m_seed_n[d]++;
        if (m_seed_n[d] == 31) begin
          m_seed_n[d] = 0;
          ones = 0;
          for (int i = 0; i < hist[d].size(); i++) ones += int'(hist[d][i]);
          if (ones != 0) begin
            m_chk[d] = 1'b1;
            m_wb[d] = 0;
            m_we[d] = 0;
          end
        end
      end else begin
        n = hist[d].size();
        p = hist[d][n-28] ^ hist[d][n-31];
        er = b ^ p;
        hist[d].push_back(p);
        void'(hist[d].pop_front());
        m_bits[d] = m_bits[d] + 32'd1;
        if (er && m_cnt[d] < m_max[d]) m_cnt[d]++;
        m_wb[d]++;
        m_we[d] += int'(er);
        if (m_wb[d] == WIN) begin
          if (m_we[d] >= m_th[d]) begin
            m_chk[d] = 1'b0;
            m_seed_n[d] = 0;
          end
          m_wb[d] = 0;
          m_we[d] = 0;
        end
      end
    end
    if (c) begin
      m_cnt[d] = 0;
      m_bits[d] = '0;
    end
    e.locked = m_chk[d];
    e.pulse  = was && v && er;
    e.cnt    = 16'(m_cnt[d]);
    e.bits   = m_bits[d];
    sbq[d].push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    bit   bad;
    for (int d = 0; d < 2; d++) begin
      if (sbq[d].size() > 0) begin
        e = sbq[d].pop_front();
        nvec++;
        bad = (locked_w[d] !== e.locked) || (pulse_w[d] !== e.pulse) || (cnt_w[d] !== e.cnt);
`ifdef PRBS31_CHK_BITCNT_EN
        bad = bad || (bc_w[d] !== e.bits);
`endif
        if (bad) begin
          nmis++;
          $display("FAIL scoreboard dut%0d: got locked=%0b pulse=%0b cnt=%0d bits=%0d, expected locked=%0b pulse=%0b cnt=%0d bits=%0d",
                   d, locked_w[d], pulse_w[d], cnt_w[d], bc_w[d], e.locked, e.pulse, e.cnt, e.bits);
        end
        if (pulse_w[d] === 1'b1) npulse[d]++;
        if (locked_w[d] !== 1'b1) nunlk[d]++;
        else nlk[d]++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // inputs are applied at negedge+1 and held through the next posedge
  task automatic step(input logic v, input logic b, input logic c);
    din_valid = v;
    din = b;
    clr_cnt = c;
    model_step(0, v, b, c);
    model_step(1, v, b, c);
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int n, input bit inv, input int gap_pct);
    bit b;
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) < gap_pct) step(1'b0, 1'($urandom), 1'b0);
      b = gen_next();
      step(1'b1, b ^ inv, 1'b0);
    end
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    clr_cnt = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit b;
    bit v;
    bit c;
    for (int i = 0; i < 31; i++) gen.push_back(i == 0);
    for (int d = 0; d < 2; d++) begin
      npulse[d] = 0;
      nunlk[d] = 0;
      nlk[d] = 0;
    end
    model_reset();
    @(negedge clk);
    #1;
    chk("reset_locked", 32'(locked0), 32'd0);
    chk("reset_pulse", 32'(pulse0), 32'd0);
    chk("reset_cnt", 32'(cnt0), 32'd0);
    chk("reset_locked1", 32'(locked1), 32'd0);
    rst_n = 1'b1;

    // stuck-at-0 line never locks
    for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 1'b0);
    chk("zeros_never_locked", 32'(nlk[0]), 32'd0);
    chk("zeros_cnt", 32'(cnt0), 32'd0);

    // clean stream locks on the 31st bit
    do_reset();
    npulse[0] = 0;
    send(30, 1'b0, 0);
    chk("lock_after_30", 32'(locked0), 32'd0);
    send(1, 1'b0, 0);
    chk("lock_after_31", 32'(locked0), 32'd1);
    send(469, 1'b0, 0);
    chk("clean_cnt", 32'(cnt0), 32'd0);
    chk("clean_pulses", 32'(npulse[0]), 32'd0);

    // single flipped bit counted once, lock held
    nunlk[0] = 0;
    send(99, 1'b0, 0);
    send(1, 1'b1, 0);
    send(200, 1'b0, 0);
    chk("single_err_pulses", 32'(npulse[0]), 32'd1);
    chk("single_err_cnt", 32'(cnt0), 32'd1);
    chk("single_err_lock_held", 32'(nunlk[0]), 32'd0);

    // inverted data for one aligned window drops lock, clean data relocks
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < WIN && m_wb[0] != 0; i++) send(1, 1'b0, 0);
    send(63, 1'b1, 0);
    chk("inv_locked_63", 32'(locked0), 32'd1);
    send(1, 1'b1, 0);
    chk("inv_cnt", 32'(cnt0), 32'd64);
    chk("inv_unlocked", 32'(locked0), 32'd0);
    chk("inv_unlocked1", 32'(locked1), 32'd0);
    send(30, 1'b0, 0);
    chk("relock_30", 32'(locked0), 32'd0);
    send(1, 1'b0, 0);
    chk("relock_31", 32'(locked0), 32'd1);

    // 4-bit counter saturation and clr priority on the second instance
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 60; i++) send(1, (i % 3) == 2, 0);
    chk("sat_cnt1", 32'(cnt1), 32'd15);
    chk("sat_locked1", 32'(locked1), 32'd1);
    b = gen_next();
    step(1'b1, ~b, 1'b1);
    chk("clr_err_pulse1", 32'(pulse1), 32'd1);
    chk("clr_err_cnt1", 32'(cnt1), 32'd0);

    // asynchronous reset between edges
    din_valid = 1'b0;
    clr_cnt = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_locked1", 32'(locked1), 32'd0);
    chk("async_pulse1", 32'(pulse1), 32'd0);
    chk("async_cnt0", 32'(cnt0), 32'd0);
    chk("async_bits0", bc_w[0], 32'd0);
    model_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // clean stream with random valid gaps
    npulse[0] = 0;
    send(500, 1'b0, 30);
    chk("gaps_locked", 32'(locked0), 32'd1);
    chk("gaps_cnt", 32'(cnt0), 32'd0);
    chk("gaps_pulses", 32'(npulse[0]), 32'd0);
`ifdef PRBS31_CHK_BITCNT_EN
    chk("gaps_bits", bc_w[0], 32'd469);
`endif

    // random errors, gaps and clears
    for (int i = 0; i < 1500; i++) begin
      v = ($urandom_range(99) < 75);
      c = ($urandom_range(99) == 0);
      b = 1'b0;
      if (v) b = gen_next() ^ ($urandom_range(39) == 0);
      step(v, b, c);
      if (i == 700) send(40, 1'b1, 10);
    end

    step(1'b0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
